// File: rtl/sobel_output_writeback_ctrl.sv
// Sobel output write-back controller: raster tracking, interior/border address
// generation and a 2-entry first-word-fall-through write FIFO with back-pressure.
module sobel_output_writeback_ctrl #(
    parameter int IMG_W  = 5,
    parameter int IMG_H  = 5,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int KRAD   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              border_mode,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(2 * KRAD);
    localparam logic [RW-1:0] ROW_WIN  = RW'(2 * KRAD);
    localparam logic [CW-1:0] COL_BLO  = CW'(KRAD - 1);
    localparam logic [CW-1:0] COL_BHI  = CW'(IMG_W - KRAD);
    localparam logic [RW-1:0] ROW_ILO  = RW'(KRAD);
    localparam logic [RW-1:0] ROW_IHI  = RW'(IMG_H - KRAD);

    localparam logic [1:0] ST_STREAM = 2'd0;
    localparam logic [1:0] ST_SWEEP  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]        r_state;
    logic [RW-1:0]     r_row;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_sr;
    logic [CW-1:0]     r_sc;
    logic              r_mode;
    logic [ADDR_W-1:0] r_base;
    logic              r_en;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr0;
    logic [ADDR_W-1:0] r_addr1;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;

    logic              w_pop;
    logic              w_room;
    logic              w_in_fire;
    logic              w_first_px;
    logic [ADDR_W-1:0] w_base_eff;
    logic              w_mode_eff;
    logic              w_px_interior;
    logic [ADDR_W-1:0] w_px_addr;
    logic [ADDR_W-1:0] w_sw_addr;
    logic              w_sw_row_interior;
    logic              w_sw_last;
    logic              w_sw_push;
    logic              w_push;
    logic [ADDR_W-1:0] w_push_addr;
    logic [DATA_W-1:0] w_push_data;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_pop     = (r_cnt != 2'd0) && out_ready;
    assign w_room    = (r_cnt != 2'd2) || w_pop;
    assign in_ready  = r_en && (r_state == ST_STREAM) && w_room;
    assign w_in_fire = in_valid && in_ready;

    assign w_first_px = (r_row == '0) && (r_col == '0);
    assign w_base_eff = w_first_px ? base_addr   : r_base;
    assign w_mode_eff = w_first_px ? border_mode : r_mode;

    assign w_px_interior = (r_row >= ROW_WIN) && (r_col >= COL_WIN);
    assign w_px_addr = ADDR_W'(32'(w_base_eff)
                               + (32'(r_row) - 32'(KRAD)) * 32'(IMG_W)
                               + 32'(r_col) - 32'(KRAD));
    assign w_sw_addr = ADDR_W'(32'(r_base) + 32'(r_sr) * 32'(IMG_W) + 32'(r_sc));

    assign w_sw_row_interior = (r_sr >= ROW_ILO) && (r_sr < ROW_IHI);
    assign w_sw_last         = (r_sr == ROW_LAST) && (r_sc == COL_LAST);
    assign w_sw_push         = (r_state == ST_SWEEP) && w_room;

    assign w_push      = (w_in_fire && w_px_interior) || w_sw_push;
    assign w_push_addr = (r_state == ST_SWEEP) ? w_sw_addr : w_px_addr;
    assign w_push_data = (r_state == ST_SWEEP) ? '0 : in_data;

    assign out_valid  = (r_cnt != 2'd0);
    assign out_addr   = r_addr0;
    assign out_data   = r_data0;
    assign frame_done = (r_state == ST_DRAIN) && (r_cnt == 2'd1) && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_STREAM;
            r_row   <= '0;
            r_col   <= '0;
            r_sr    <= '0;
            r_sc    <= '0;
            r_mode  <= 1'b0;
            r_base  <= '0;
            r_en    <= 1'b0;
        end else begin
            r_en <= 1'b1;
            case (r_state)
                ST_STREAM: begin
                    if (w_in_fire) begin
                        if (w_first_px) begin
                            r_base <= base_addr;
                            r_mode <= border_mode;
                        end
                        if (r_col == COL_LAST) begin
                            r_col <= '0;
                            if (r_row == ROW_LAST) begin
                                r_row   <= '0;
                                r_state <= w_mode_eff ? ST_SWEEP : ST_DRAIN;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                ST_SWEEP: begin
                    // Interior rows jump straight from the left border band to the right one.
                    if (w_room) begin
                        if (w_sw_last) begin
                            r_sr    <= '0;
                            r_sc    <= '0;
                            r_state <= ST_DRAIN;
                        end else if (r_sc == COL_LAST) begin
                            r_sc <= '0;
                            r_sr <= r_sr + 1'b1;
                        end else if (w_sw_row_interior && (r_sc == COL_BLO)) begin
                            r_sc <= COL_BHI;
                        end else begin
                            r_sc <= r_sc + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((r_cnt == 2'd0) || frame_done) begin
                        r_state <= ST_STREAM;
                    end
                end
                default: r_state <= ST_STREAM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= 2'd0;
            r_addr0 <= '0;
            r_addr1 <= '0;
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_addr0 <= w_push_addr;
                        r_data0 <= w_push_data;
                    end else begin
                        r_addr1 <= w_push_addr;
                        r_data1 <= w_push_data;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_addr0 <= r_addr1;
                    r_data0 <= r_data1;
                    r_cnt   <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_addr0 <= w_push_addr;
                        r_data0 <= w_push_data;
                    end else begin
                        r_addr0 <= r_addr1;
                        r_data0 <= r_data1;
                        r_addr1 <= w_push_addr;
                        r_data1 <= w_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_output_writeback_ctrl.sv
// Bench for sobel_output_writeback_ctrl: fixed scenario table, hand-built corner
// sequences and randomized frames against a raster-level write-list model.
module tb_sobel_output_writeback_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n_a, rst_n_b, sel;
    logic          in_valid, border_mode, out_ready;
    logic [DW-1:0] in_data;
    logic [AW-1:0] base_addr;

    logic          a_in_ready, a_out_valid, a_frame_done;
    logic [AW-1:0] a_out_addr;
    logic [DW-1:0] a_out_data;
    logic          b_in_ready, b_out_valid, b_frame_done;
    logic [AW-1:0] b_out_addr;
    logic [DW-1:0] b_out_data;

    logic          w_in_ready, w_out_valid, w_frame_done;
    logic [AW-1:0] w_out_addr;
    logic [DW-1:0] w_out_data;

    assign w_in_ready   = sel ? b_in_ready   : a_in_ready;
    assign w_out_valid  = sel ? b_out_valid  : a_out_valid;
    assign w_frame_done = sel ? b_frame_done : a_frame_done;
    assign w_out_addr   = sel ? b_out_addr   : a_out_addr;
    assign w_out_data   = sel ? b_out_data   : a_out_data;

    sobel_output_writeback_ctrl #(
        .IMG_W(5), .IMG_H(5), .ADDR_W(AW), .DATA_W(DW), .KRAD(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .border_mode(border_mode), .base_addr(base_addr),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_addr(a_out_addr),
        .out_data(a_out_data), .frame_done(a_frame_done)
    );

    sobel_output_writeback_ctrl #(
        .IMG_W(7), .IMG_H(7), .ADDR_W(AW), .DATA_W(DW), .KRAD(2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .border_mode(border_mode), .base_addr(base_addr),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_addr(b_out_addr),
        .out_data(b_out_data), .frame_done(b_frame_done)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        bit         last;
    } exp_t;

    typedef struct {
        logic [7:0] base;
        bit         mode;
        int         vpct;
        int         rpct;
        int         n_wr;
        int         first_addr;
        int         first_data;
        int         last_addr;
        int         last_data;
    } vec_t;

    exp_t       expq[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         cur_w, cur_h, cur_k;
    int         m_row, m_col;
    logic [7:0] m_base;
    bit         m_mode, m_busy;
    bit         lat_pending;
    int         lat_cyc;
    logic [7:0] lat_addr;
    bit         prev_stall;
    logic [7:0] prev_addr, prev_data;
    bit         data_rand;
    bit         smp_in_ready;
    int         fw_cnt;
    int         fw_first_addr, fw_first_data, fw_last_addr, fw_last_data;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int w, input int h, input int k);
        cur_w = w; cur_h = h; cur_k = k;
        m_row = 0; m_col = 0; m_busy = 0; m_mode = 0; m_base = '0;
        lat_pending = 0; prev_stall = 0;
        expq.delete();
    endtask

    task automatic frame_begin();
        fw_cnt = 0;
    endtask

    // Write list derived from raster position: interior window writes, then the border sweep.
    task automatic model_consume(input logic [7:0] d);
        int a;
        bit lastpx;
        if (m_row == 0 && m_col == 0) begin
            m_base = base_addr;
            m_mode = border_mode;
        end
        lastpx = (m_row == cur_h - 1) && (m_col == cur_w - 1);
        if (m_row >= 2 * cur_k && m_col >= 2 * cur_k) begin
            a = int'(m_base) + (m_row - cur_k) * cur_w + (m_col - cur_k);
            expq.push_back('{addr: 8'(a), data: d, last: lastpx && !m_mode});
            if (m_row == 2 * cur_k && m_col == 2 * cur_k) begin
                lat_pending = 1;
                lat_cyc = cyc;
                lat_addr = 8'(a);
            end
        end
        if (lastpx) begin
            m_busy = 1;
            if (m_mode) begin
                for (int r = 0; r < cur_h; r++) begin
                    for (int c = 0; c < cur_w; c++) begin
                        if (!(r >= cur_k && r < cur_h - cur_k && c >= cur_k && c < cur_w - cur_k)) begin
                            a = int'(m_base) + r * cur_w + c;
                            expq.push_back('{addr: 8'(a), data: 8'd0,
                                             last: (r == cur_h - 1) && (c == cur_w - 1)});
                        end
                    end
                end
            end
        end
        m_col++;
        if (m_col == cur_w) begin
            m_col = 0;
            m_row++;
            if (m_row == cur_h) m_row = 0;
        end
    endtask

    // Called at a falling edge with inputs already driven; samples, checks, advances one cycle.
    task automatic step(output bit fired);
        exp_t e;
        bit   hs, exp_done;
        #1;
        cyc++;
        smp_in_ready = w_in_ready;
        hs = w_out_valid && out_ready;
        if (prev_stall) begin
            chk("hold_valid", w_out_valid, 1);
            chk("hold_addr", w_out_addr, prev_addr);
            chk("hold_data", w_out_data, prev_data);
        end
        if (lat_pending && cyc == lat_cyc + 1) begin
            chk("first_write_valid", w_out_valid, 1);
            chk("first_write_addr", w_out_addr, lat_addr);
            lat_pending = 0;
        end
        if (m_busy) chk("in_ready_busy", w_in_ready, 0);
        exp_done = 0;
        if (hs) begin
            chk("write_expected", int'(expq.size() > 0), 1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("wr_addr", w_out_addr, e.addr);
                chk("wr_data", w_out_data, e.data);
                exp_done = e.last;
                if (fw_cnt == 0) begin
                    fw_first_addr = w_out_addr;
                    fw_first_data = w_out_data;
                end
                fw_last_addr = w_out_addr;
                fw_last_data = w_out_data;
                fw_cnt++;
            end
        end
        chk("frame_done", w_frame_done, exp_done);
        if (exp_done) m_busy = 0;
        fired = in_valid && w_in_ready;
        if (fired) model_consume(in_data);
        prev_stall = w_out_valid && !out_ready;
        prev_addr  = w_out_addr;
        prev_data  = w_out_data;
        @(negedge clk);
    endtask

    task automatic drive_pixel();
        in_data = data_rand ? 8'($urandom) : 8'(m_row * cur_w + m_col);
    endtask

    task automatic feed(input int n, input int vpct, input int rpct, input bit scramble);
        int got = 0;
        int guard = 0;
        bit fired;
        while (got < n && guard < 2000) begin
            if (scramble && !(m_row == 0 && m_col == 0)) begin
                base_addr = 8'($urandom);
                border_mode = 1'($urandom);
            end
            in_valid = ($urandom_range(99) < vpct);
            drive_pixel();
            out_ready = ($urandom_range(99) < rpct);
            step(fired);
            if (fired) got++;
            guard++;
        end
        chk("feed_pixels", got, n);
    endtask

    task automatic drain(input int rpct);
        int guard = 0;
        bit fired;
        while ((expq.size() != 0 || m_busy) && guard < 1000) begin
            in_valid = m_busy;
            in_data = 8'($urandom);
            out_ready = ($urandom_range(99) < rpct);
            step(fired);
            guard++;
        end
        chk("drain_in_time", int'(guard < 1000), 1);
        repeat (3) begin
            in_valid = 0;
            out_ready = 1;
            step(fired);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        bit   fired;
        int   exp_n;

        tbl[0] = '{8'd0,   1'b0, 100, 100,  9, 6, 12, 18, 24};
        tbl[1] = '{8'd0,   1'b1, 100, 100, 25, 6, 12, 24,  0};
        tbl[2] = '{8'd250, 1'b0, 100, 100,  9, 0, 12, 12, 24};
        tbl[3] = '{8'd250, 1'b1,  70,  60, 25, 0, 12, 18,  0};

        sel = 0; rst_n_a = 0; rst_n_b = 0;
        in_valid = 0; in_data = '0; out_ready = 0; border_mode = 0; base_addr = '0;
        data_rand = 0;
        model_reset(5, 5, 1);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_addr", a_out_addr, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_frame_done", a_frame_done, 0);
        chk("rst_in_ready", a_in_ready, 0);
        rst_n_a = 1;
        @(negedge clk);
        #1;
        chk("in_ready_after_release", a_in_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            base_addr = tbl[i].base;
            border_mode = tbl[i].mode;
            data_rand = 0;
            frame_begin();
            feed(25, tbl[i].vpct, tbl[i].rpct, 0);
            drain((tbl[i].rpct < 30) ? 30 : tbl[i].rpct);
            chk("tbl_count", fw_cnt, tbl[i].n_wr);
            chk("tbl_first_addr", fw_first_addr, tbl[i].first_addr);
            chk("tbl_first_data", fw_first_data, tbl[i].first_data);
            chk("tbl_last_addr", fw_last_addr, tbl[i].last_addr);
            chk("tbl_last_data", fw_last_data, tbl[i].last_data);
        end

        // Back-pressure: stall the buffer as the first two interior pixels arrive.
        base_addr = 8'd0; border_mode = 0; data_rand = 0;
        frame_begin();
        feed(12, 100, 100, 0);
        for (int s = 0; s < 6; s++) begin
            in_valid = 1;
            drive_pixel();
            out_ready = 0;
            step(fired);
            if (s < 2) chk("bp_accept", fired, 1);
            else       chk("bp_in_ready", smp_in_ready, 0);
        end
        feed(11, 100, 100, 0);
        drain(100);
        chk("bp_count", fw_cnt, 9);
        chk("bp_last_addr", fw_last_addr, 18);

        // Reset in the middle of a frame, then a clean frame.
        base_addr = 8'd0; border_mode = 0; data_rand = 0;
        frame_begin();
        feed(15, 100, 100, 0);
        rst_n_a = 0; in_valid = 0; out_ready = 1;
        @(negedge clk);
        rst_n_a = 1;
        model_reset(5, 5, 1);
        #1;
        chk("midrst_out_valid", a_out_valid, 0);
        chk("midrst_out_addr", a_out_addr, 0);
        chk("midrst_out_data", a_out_data, 0);
        chk("midrst_frame_done", a_frame_done, 0);
        chk("midrst_in_ready", a_in_ready, 0);
        @(negedge clk);
        #1;
        chk("midrst_in_ready_rise", a_in_ready, 1);
        @(negedge clk);
        frame_begin();
        feed(25, 100, 100, 0);
        drain(100);
        chk("midrst_count", fw_cnt, 9);
        chk("midrst_first_addr", fw_first_addr, 6);
        chk("midrst_first_data", fw_first_data, 12);
        chk("midrst_last_addr", fw_last_addr, 18);
        chk("midrst_last_data", fw_last_data, 24);

        for (int fr = 0; fr < 6; fr++) begin
            base_addr = 8'($urandom);
            border_mode = 1'($urandom);
            data_rand = 1;
            frame_begin();
            feed(25, $urandom_range(100, 40), $urandom_range(100, 30), 1);
            drain(60);
            exp_n = m_mode ? 25 : 9;
            chk("rnd_count", fw_cnt, exp_n);
        end

        // 7x7 image with a 5x5 kernel.
        rst_n_a = 0;
        sel = 1;
        in_valid = 0;
        rst_n_b = 1;
        model_reset(7, 7, 2);
        @(negedge clk);
        base_addr = 8'd0; border_mode = 0; data_rand = 0;
        frame_begin();
        feed(49, 100, 100, 0);
        drain(100);
        chk("k2_count", fw_cnt, 9);
        chk("k2_first_addr", fw_first_addr, 16);
        chk("k2_first_data", fw_first_data, 32);
        chk("k2_last_addr", fw_last_addr, 32);

        base_addr = 8'($urandom); border_mode = 1; data_rand = 1;
        frame_begin();
        feed(49, 80, 70, 1);
        drain(70);
        chk("k2_sweep_count", fw_cnt, 49);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sobel_output_writeback_ctrl.md
Name: sobel_output_writeback_ctrl

Overview:
- Next-generation Sobel output address generator and write-back controller; sits between the Sobel magnitude stage and the output frame buffer.
- Tracks raster position internally from an input pixel stream; generalises kernel radius; adds a runtime base address and an optional zero-fill border sweep.
- Adds valid/ready back-pressure through a 2-entry output FIFO and a per-frame done pulse.

Parameters:
- IMG_W, 5, image width in pixels; must be > 2*KRAD.
- IMG_H, 5, image height in pixels; must be > 2*KRAD.
- ADDR_W, 8, output address width.
- DATA_W, 8, Sobel magnitude width.
- KRAD, 1, kernel radius (1 = 3x3, 2 = 5x5).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  Sobel result valid for the newest streamed pixel
- in_ready  out  1  block accepts the input this cycle
- in_data  in  DATA_W  Sobel magnitude for the window ending at the current pixel
- border_mode  in  1  0 = skip borders, 1 = zero-fill borders after the stream
- base_addr  in  ADDR_W  frame base address in the output buffer
- out_valid  out  1  write request valid
- out_ready  in  1  buffer accepts the write
- out_addr  out  ADDR_W  write address
- out_data  out  DATA_W  write data
- frame_done  out  1  one-cycle pulse when the frame's last write is accepted

Behaviour:
- Reset (rst_n low at posedge) clears all outputs, row/col counters and the FIFO.
  - Reset values: out_valid=0, out_addr=0, out_data=0, frame_done=0, in_ready=0.
  - State=STREAM; in_ready rises the cycle after reset is released.
- Reset mid-frame discards all FIFO contents and counters. The next accepted pixel is treated as (0,0).
- Input handshake: a pixel is consumed when in_valid && in_ready. in_ready = (state==STREAM) && FIFO not full.
- Counters:
  - col increments 0..IMG_W-1 per consumed pixel, wraps to 0 and increments row 0..IMG_H-1.
  - border_mode and base_addr are sampled at pixel (0,0) and held for the frame.
- Interior write:
  - Condition: consumed pixel with row>=2*KRAD and col>=2*KRAD.
  - Pushes addr = base + (row-KRAD)*IMG_W + (col-KRAD) and in_data.
  - Pixels failing the condition are consumed silently.
- Address arithmetic: computed at full internal width, truncated modulo 2^ADDR_W (wrap, no error).
- FIFO:
  - 2 entries, first-word fall-through.
  - out_* reflect the head entry; out_data/out_addr hold their value while out_valid && !out_ready.
  - Latency: consumed interior pixel appears on out_* the cycle after consumption when the FIFO is empty.
  - Simultaneous push and pop when full is legal; in_ready deasserts only when full with no pop.
- States:
  - STREAM: on consuming pixel (IMG_H-1, IMG_W-1), go to SWEEP if border_mode=1, else to DRAIN.
  - SWEEP:
    - Scans r=0..IMG_H-1, c=0..IMG_W-1 in raster order, skipping interior coordinates.
    - Interior = KRAD<=r<IMG_H-KRAD and KRAD<=c<IMG_W-KRAD.
    - Pushes (base + r*IMG_W + c, 0), one per cycle when the FIFO is not full.
    - After the last border coordinate, go to DRAIN. in_ready=0 throughout.
  - DRAIN: wait for the FIFO to empty. frame_done pulses in the cycle the final entry's handshake occurs, then return to STREAM with counters at 0. in_ready=0.
- No write is ever dropped or duplicated. out_valid must not deassert without a handshake.

Test Plan:
- IMG 5x5, KRAD=1, base=0, mode 0, out_ready=1, 25 pixels with data = pixel index -> 9 writes.
  - Addrs 6,7,8,11,12,13,16,17,18 with data 12,13,14,17,18,19,22,23,24.
  - First write appears the cycle after pixel 12 is consumed; frame_done coincides with the addr-18 handshake.
- Same stream, mode 1 -> the 9 interior writes, then 16 zero writes at 0-5,9,10,14,15,19-24 in that order.
  - in_ready=0 during SWEEP; frame_done is on the addr-24 handshake.
- Back-pressure: out_ready=0 for 6 cycles mid-frame.
  - in_ready drops after 2 entries queue; out_addr/out_data stay stable.
  - All 9 writes arrive in order after release.
- base_addr=250, ADDR_W=8, mode 0 -> first addrs 0,1,2 (256..258 wrapped), last addr 12.
- IMG 7x7, KRAD=2, base=0 -> first write addr 16 after pixel (4,4); 9 writes total; last addr 32.
- rst_n low for 1 cycle after 15 pixels of a frame.
  - Outputs clear and no stale write is emitted.
  - A full fresh 25-pixel frame then produces exactly the 9 writes from the first scenario.
